axis_rgb_plane_interleaver: RTL and testbench
=============================================

Name: axis_rgb_plane_interleaver

Overview:
- Converts a planar 8-bit AXI-Stream image (all R bytes, then all G bytes, then all B bytes) into an interleaved 24-bit RGB pixel stream.
- Sits between the DDR read DMA (byte stream master) and the first convolution layer (pixel stream consumer).
- Buffers the R and G planes internally, then emits one packed pixel per accepted B byte, with TLAST on the final pixel of each frame.

Parameters:
- IMG_PIXELS, 1024, pixels per frame (plane length in bytes); must be >= 2.
- IDX_W, $clog2(IMG_PIXELS), width of the pixel index and plane-memory address.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_tvalid  input  1  input byte valid.
- s_tdata  input  8  input byte (planar R|G|B order).
- s_tready  output  1  input byte accepted when s_tvalid && s_tready at a clock edge.
- m_tvalid  output  1  output pixel valid.
- m_tdata  output  24  packed pixel, [23:16]=R, [15:8]=G, [7:0]=B.
- m_tlast  output  1  high with the last pixel (index IMG_PIXELS-1) of a frame.
- m_tready  input  1  downstream ready.

Behaviour:
- Storage: r_mem and g_mem, each IMG_PIXELS x 8. Synchronous write; asynchronous (combinational) read. Contents are not reset.
- State: phase in {PH_R, PH_G, PH_B} and idx (IDX_W bits). Reset values: phase=PH_R, idx=0.
- Output reset values: m_tvalid=0, m_tdata=0, m_tlast=0.
- PH_R:
  - s_tready=1.
  - On each input handshake, r_mem[idx] <= s_tdata and idx increments.
  - At idx==IMG_PIXELS-1, idx wraps to 0 and phase becomes PH_G.
- PH_G: identical to PH_R but writes g_mem; at the last byte, goes to PH_B with idx=0.
- PH_B:
  - s_tready = !m_tvalid || m_tready (one-entry output register).
  - On each input handshake: m_tdata <= {r_mem[idx], g_mem[idx], s_tdata}, m_tvalid <= 1, m_tlast <= (idx==IMG_PIXELS-1), idx increments.
  - At the last byte, idx=0 and phase returns to PH_R, ready for the next frame.
- Output register:
  - If m_tvalid && m_tready and no new B byte is accepted in the same cycle, m_tvalid <= 0 and m_tlast <= 0.
  - A simultaneous pop and push loads the new pixel; m_tvalid stays 1 and full throughput is sustained.
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready (AXI-Stream rule).
- Latency: a pixel appears on m_* the cycle after its B byte handshake.
- Throughput: 1 byte per cycle in every phase. During PH_R and PH_G, m_tvalid stays 0 except while the final pixel of the previous frame is still pending.
- Frame overlap: in PH_R the next frame's R bytes may be accepted while the previous last pixel is stalled.
  - r_mem is overwritten only at indices already emitted, so this is safe.
  - g_mem is not written until PH_G, so this is safe.
- s_tvalid low: no state change. Bytes with s_tvalid low are ignored.
- No input TLAST. Frame boundaries come purely from counting 3*IMG_PIXELS bytes.
- Reset mid-frame clears phase, idx and the output register immediately and asynchronously. Any partially buffered frame is discarded; the next accepted byte is treated as R[0].
- No data transformation: bytes are passed bit-exact.

Test Plan:
- Full frame, IMG_PIXELS=1024, DMA reading DDR laid out R|G|B from image_r/g/b.mem, m_tready=1 -> pixel n equals {R[n],G[n],B[n]} for n=0..1023; exactly 1024 m_tvalid beats; m_tlast only on beat 1023.
- IMG_PIXELS=4, bytes 0x10..0x13, 0x20..0x23, 0x30..0x33 -> m_tdata 0x102030, 0x112131, 0x122232, 0x132333; m_tlast on 0x132333; first m_tvalid one cycle after byte 0x30 handshake.
- Backpressure, IMG_PIXELS=4: m_tready toggles 1,0,0,1,... during PH_B -> s_tready drops while the pixel is stalled; m_tdata stable while stalled; no pixel lost or duplicated.
- Back-to-back frames, IMG_PIXELS=4, two frames (second frame = first +0x40) with m_tready held low on the last pixel of frame 1 -> frame 2 R bytes still accepted; frame 2 outputs 0x506070..0x536373 with correct TLAST.
- Reset mid-frame: assert rst after 6 bytes (IMG_PIXELS=4), then send a clean 12-byte frame -> m_tvalid=0 during reset; output equals the clean frame exactly.
- Input gaps: s_tvalid randomly deasserted 50% -> output identical to the gap-free case.

Source files
------------

// File: rtl/axis_rgb_plane_interleaver_if.sv
// AXI-Stream style valid/ready bundle, parameterised on data width.
// Shared by the planar byte input and the packed pixel output.
interface axis_rgb_plane_interleaver_if #(
    parameter int unsigned DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_rgb_plane_interleaver.sv
// Planar R|G|B byte stream to interleaved 24-bit RGB pixel stream.
// R and G planes are buffered; each accepted B byte emits one packed pixel.
module axis_rgb_plane_interleaver #(
    parameter int unsigned IMG_PIXELS = 1024,
    parameter int unsigned IDX_W      = $clog2(IMG_PIXELS)
) (
    input  logic                                clk,
    input  logic                                rst,
    axis_rgb_plane_interleaver_if.slave         s_axis,
    axis_rgb_plane_interleaver_if.master        m_axis
);

    typedef enum logic [1:0] {
        PhR,
        PhG,
        PhB
    } phase_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(IMG_PIXELS - 1);

    phase_e           phase;
    logic [IDX_W-1:0] idx;
    logic [7:0]       r_mem [IMG_PIXELS];
    logic [7:0]       g_mem [IMG_PIXELS];

    logic             out_valid;
    logic             out_last;
    logic [23:0]      out_data;

    logic             in_ready;
    logic             accept;
    logic             idx_last;

    // The input carries no frame marker; frames are delimited by counting.
    logic unused_s_tlast;
    assign unused_s_tlast = s_axis.tlast;

    // Only the B phase feeds the one-entry output register.
    assign in_ready = (phase != PhB) || !out_valid || m_axis.tready;
    assign accept   = s_axis.tvalid && in_ready;
    assign idx_last = (idx == LastIdx);

    assign s_axis.tready = in_ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tlast  = out_last;

    // Plane storage is not reset; each frame rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (accept && (phase == PhR)) begin
            r_mem[idx] <= s_axis.tdata;
        end
        if (accept && (phase == PhG)) begin
            g_mem[idx] <= s_axis.tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= PhR;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            // A pop may be overridden below by a simultaneous push.
            if (out_valid && m_axis.tready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (accept) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
                unique case (phase)
                    PhR: begin
                        if (idx_last) phase <= PhG;
                    end
                    PhG: begin
                        if (idx_last) phase <= PhB;
                    end
                    PhB: begin
                        out_data  <= {r_mem[idx], g_mem[idx], s_axis.tdata};
                        out_valid <= 1'b1;
                        out_last  <= idx_last;
                        if (idx_last) phase <= PhR;
                    end
                    default: phase <= PhR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_rgb_plane_interleaver.sv
// Scoreboard bench: frames are modelled as whole R|G|B byte arrays and the
// expected pixel list is queued up front; a monitor pops on every output beat.
module tb_axis_rgb_plane_interleaver;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_rgb_plane_interleaver_if #(.DATA_W(8))  s_axis ();
    axis_rgb_plane_interleaver_if #(.DATA_W(24)) m_axis ();

    axis_rgb_plane_interleaver #(
        .IMG_PIXELS(N),
        .IDX_W     ($clog2(N))
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axis(s_axis),
        .m_axis(m_axis)
    );

    int          vectors    = 0;
    int          miscompares = 0;
    logic [24:0] exp_q[$];
    logic [7:0]  frame [3*N];
    int          pos   = 0;   // bytes accepted within the current frame
    int          rmode = 0;   // 0 ready, 1 pattern 1,0,0, 2 held low, 3 random
    bit          gaps  = 1'b0;
    int          cyc   = 0;

    logic        stall_prev = 1'b0;
    logic [24:0] held;
    logic [24:0] exp_pix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: pixel n of a planar frame is {R[n], G[n], B[n]}.
    task automatic push_expected();
        for (int n = 0; n < N; n++) begin
            exp_q.push_back({(n == N - 1), frame[n], frame[N + n], frame[2 * N + n]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int t;
        ok = 1'b0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                s_axis.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = b;
        t = 0;
        forever begin
            @(negedge clk);
            ok = s_axis.tready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 100) begin
                check("s_handshake_timeout", 32'(0), 32'(1));
                break;
            end
        end
        s_axis.tvalid = 1'b0;
        if (ok) pos = (pos + 1) % (3 * N);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_byte(frame[i]);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic fill_pattern(input logic [7:0] base);
        for (int n = 0; n < N; n++) begin
            frame[n]         = base + 8'h10 + 8'(n);
            frame[N + n]     = base + 8'h20 + 8'(n);
            frame[2 * N + n] = base + 8'h30 + 8'(n);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 3 * N; i++) frame[i] = 8'($urandom);
    endtask

    // Downstream ready generator.
    initial begin
        m_axis.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rmode)
                0:       m_axis.tready = 1'b1;
                1:       m_axis.tready = (cyc % 3 == 0);
                2:       m_axis.tready = 1'b0;
                default: m_axis.tready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Monitor: beat scoreboard, stall stability and input-ready rule.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("valid_in_reset", 32'(m_axis.tvalid), 32'(0));
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", 32'(m_axis.tvalid), 32'(1));
                    check("stall_data_held", 32'({m_axis.tlast, m_axis.tdata}), 32'(held));
                end
                check("s_tready_rule", 32'(s_axis.tready),
                      32'((pos < 2 * N) || !m_axis.tvalid || m_axis.tready));
                if (m_axis.tvalid && m_axis.tready) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) begin
                        exp_pix = exp_q.pop_front();
                        check("pixel", 32'({m_axis.tlast, m_axis.tdata}), 32'(exp_pix));
                    end
                end
                stall_prev = m_axis.tvalid && !m_axis.tready;
                held       = {m_axis.tlast, m_axis.tdata};
            end
        end
    end

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", 32'(m_axis.tvalid), 32'(0));
        check("reset_tdata", 32'(m_axis.tdata), 32'(0));
        check("reset_tlast", 32'(m_axis.tlast), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed frame with first-pixel latency checks.
        fill_pattern(8'h00);
        push_expected();
        send_range(0, 2 * N);
        check("no_valid_before_b", 32'(m_axis.tvalid), 32'(0));
        send_byte(frame[2 * N]);
        check("first_pixel_latency", 32'({m_axis.tvalid, m_axis.tdata}), 32'({1'b1, 24'h102030}));
        send_range(2 * N + 1, 3 * N);
        drain();

        // Backpressure pattern during the B phase.
        rmode = 1;
        fill_pattern(8'h05);
        push_expected();
        send_range(0, 3 * N);
        drain();
        rmode = 0;

        // Back-to-back frames with the last pixel of frame 1 stalled.
        fill_pattern(8'h00);
        push_expected();
        send_range(0, 3 * N - 1);
        rmode = 2;
        send_byte(frame[3 * N - 1]);
        fill_pattern(8'h40);
        push_expected();
        send_range(0, N);
        check("last_pixel_still_pending", 32'({m_axis.tvalid, m_axis.tlast}), 32'(2'b11));
        rmode = 0;
        send_range(N, 3 * N);
        drain();

        // Reset mid-frame discards the partial frame.
        fill_random();
        send_range(0, 6);
        rst = 1'b1;
        pos = 0;
        #1;
        check("async_reset_tvalid", 32'(m_axis.tvalid), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fill_random();
        push_expected();
        send_range(0, 3 * N);
        drain();

        // Random gaps and random downstream ready.
        gaps  = 1'b1;
        rmode = 3;
        for (int f = 0; f < 6; f++) begin
            fill_random();
            push_expected();
            send_range(0, 3 * N);
        end
        rmode = 0;
        gaps  = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
